// File: rtl/slink_rxpack_pkg.sv
// slink receive packer shared definitions.
// Word field offsets, legal sizes and receive states.
package slink_rxpack_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_PKT,
        RX_DISC
    } rx_state_e;

    function automatic int slink_data_lsb(int nbyte);
        return 0 * nbyte;
    endfunction

    function automatic int slink_mod_lsb(int nbyte);
        return 8 * nbyte;
    endfunction

    function automatic int slink_eop_bit(int nbyte);
        return 8 * nbyte + $clog2(nbyte);
    endfunction

    function automatic int slink_sop_bit(int nbyte);
        return slink_eop_bit(nbyte) + 1;
    endfunction

    function automatic bit slink_nbyte_ok(int nbyte);
        return (nbyte == 2) || (nbyte == 4) || (nbyte == 8);
    endfunction

endpackage

// File: rtl/slink_sdpram.sv
// Simple dual-port RAM: one write port, registered read port.
// Only the read register is reset; the array is not.
module slink_sdpram #(
    parameter int W  = 19,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/slink_rxpack.sv
// slink MAC RX byte-to-word packer with store-and-forward packet FIFO.
// Packets become visible only once complete and error-free.
module slink_rxpack
    import slink_rxpack_pkg::*;
#(
    parameter int NBYTE = 2,
    parameter int DEPTH = 1024,
    parameter int MODW  = $clog2(NBYTE),
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic                      clk_sys,
    input  logic                      rst_sys,
    input  logic                      macrx_rxfifo_dval,
    input  logic                      macrx_rxfifo_sop,
    input  logic                      macrx_rxfifo_eop,
    input  logic                      macrx_rxfifo_err,
    input  logic [7:0]                macrx_rxfifo_data,
    input  logic                      mm_slink_rdreq,
    output logic                      slink_mm_empty,
    output logic                      slink_mm_dval,
    output logic [8*NBYTE+2+MODW-1:0] slink_mm_data,
    output logic [PW:0]               slink_mm_pktcnt,
    output logic                      slink_drop
);

    localparam int W    = 8 * NBYTE + 2 + MODW;
    localparam int DW   = 8 * NBYTE;
    localparam int EOPB = slink_eop_bit(NBYTE);

    rx_state_e       state, state_nxt;
    logic [MODW-1:0] lane, lane_cur;
    logic [DW-1:0]   acc, acc_nxt;
    logic            sop_pend;
    logic            take, emit, rewind, disc_eop;

    logic            w_vld, w_sop, w_eop, w_end, w_good;
    logic [MODW-1:0] w_mod;
    logic [DW-1:0]   w_data;

    logic [PW:0]     wr_ptr, wr_inc, commit_ptr, rd_ptr;
    logic            ovf, full, wr_ok, ram_we, commit, rden, rd_eop;

    always_comb begin
        take     = macrx_rxfifo_dval
                 & (macrx_rxfifo_sop | (state == RX_PKT));
        rewind   = macrx_rxfifo_dval & macrx_rxfifo_sop
                 & (state != RX_IDLE);
        disc_eop = macrx_rxfifo_dval & macrx_rxfifo_eop
                 & ~macrx_rxfifo_sop & (state == RX_DISC);
        lane_cur = macrx_rxfifo_sop ? '0 : lane;
        acc_nxt  = macrx_rxfifo_sop ? '0 : acc;
        // first byte of a word lands in the top byte
        for (int i = 0; i < NBYTE; i++)
            if (lane_cur == MODW'(i))
                acc_nxt[DW-8-8*i +: 8] = macrx_rxfifo_data;
        emit = take & (macrx_rxfifo_eop
             | (lane_cur == MODW'(NBYTE - 1)));
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RX_IDLE:
                if (macrx_rxfifo_dval & macrx_rxfifo_sop
                    & ~macrx_rxfifo_eop)
                    state_nxt = RX_PKT;
            RX_PKT:
                if (macrx_rxfifo_dval & macrx_rxfifo_eop)
                    state_nxt = RX_IDLE;
                else if (macrx_rxfifo_dval & macrx_rxfifo_sop)
                    state_nxt = RX_PKT;
                else if (ovf)
                    state_nxt = RX_DISC;
            RX_DISC:
                if (macrx_rxfifo_dval & macrx_rxfifo_eop)
                    state_nxt = RX_IDLE;
                else if (macrx_rxfifo_dval & macrx_rxfifo_sop)
                    state_nxt = RX_PKT;
            default:
                state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            state    <= RX_IDLE;
            lane     <= '0;
            acc      <= '0;
            sop_pend <= 1'b0;
            w_vld    <= 1'b0;
            w_end    <= 1'b0;
            w_good   <= 1'b0;
            w_sop    <= 1'b0;
            w_eop    <= 1'b0;
            w_mod    <= '0;
            w_data   <= '0;
        end else begin
            state  <= state_nxt;
            w_vld  <= emit;
            w_end  <= (take & macrx_rxfifo_eop) | disc_eop;
            w_good <= take & macrx_rxfifo_eop & ~macrx_rxfifo_err;
            if (take) begin
                w_data <= acc_nxt;
                w_sop  <= macrx_rxfifo_sop | sop_pend;
                w_eop  <= macrx_rxfifo_eop;
                w_mod  <= lane_cur + MODW'(1);
            end
            if (emit | disc_eop) begin
                lane     <= '0;
                acc      <= '0;
                sop_pend <= 1'b0;
            end else if (take) begin
                lane     <= lane_cur + MODW'(1);
                acc      <= acc_nxt;
                sop_pend <= macrx_rxfifo_sop | sop_pend;
            end
        end
    end

    // one slot is kept free so a full FIFO never looks empty
    always_comb begin
        wr_inc = wr_ptr + 1'b1;
        full   = (wr_inc[PW-1:0] == rd_ptr[PW-1:0]);
        wr_ok  = w_vld & ~ovf & ~full;
        ram_we = wr_ok & ~rewind;
        commit = ~rewind & w_end & w_good & wr_ok;
    end

    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            ovf        <= 1'b0;
            slink_drop <= 1'b0;
        end else begin
            slink_drop <= 1'b0;
            if (rewind) begin
                wr_ptr     <= commit_ptr;
                ovf        <= 1'b0;
                slink_drop <= 1'b1;
            end else if (w_end) begin
                if (commit) begin
                    wr_ptr     <= wr_inc;
                    commit_ptr <= wr_inc;
                end else begin
                    wr_ptr     <= commit_ptr;
                    slink_drop <= 1'b1;
                end
                ovf <= 1'b0;
            end else if (wr_ok) begin
                wr_ptr <= wr_inc;
            end else if (w_vld & ~ovf) begin
                ovf <= 1'b1;
            end
        end
    end

    assign slink_mm_empty = (rd_ptr == commit_ptr);
    assign rden           = mm_slink_rdreq & ~slink_mm_empty;
    assign rd_eop         = slink_mm_dval & slink_mm_data[EOPB];

    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            rd_ptr          <= '0;
            slink_mm_dval   <= 1'b0;
            slink_mm_pktcnt <= '0;
        end else begin
            slink_mm_dval <= rden;
            if (rden)
                rd_ptr <= rd_ptr + 1'b1;
            if (commit & ~rd_eop)
                slink_mm_pktcnt <= slink_mm_pktcnt + 1'b1;
            else if (~commit & rd_eop)
                slink_mm_pktcnt <= slink_mm_pktcnt - 1'b1;
        end
    end

    slink_sdpram #(
        .W  (W),
        .AW (PW)
    ) u_ram (
        .clk   (clk_sys),
        .rst_n (rst_sys),
        .we    (ram_we),
        .waddr (wr_ptr[PW-1:0]),
        .wdata ({w_sop, w_eop, w_mod, w_data}),
        .re    (rden),
        .raddr (rd_ptr[PW-1:0]),
        .rdata (slink_mm_data)
    );

endmodule

// File: tb/tb_slink_rxpack.sv
// Directed bench for slink_rxpack.
// Unit 0: NBYTE=2 DEPTH=16, unit 1: NBYTE=4 DEPTH=16.
module tb_slink_rxpack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n, dv, sp, ep, er, rq;
    logic [7:0]  bd [2];
    logic [1:0]  emp, mdv, drp;
    logic [18:0] q0;
    logic [35:0] q1;
    logic [4:0]  pc0, pc1;

    int checks = 0;
    int errors = 0;
    int drops0 = 0;
    int drops1 = 0;
    int d0;

    slink_rxpack #(.NBYTE(2), .DEPTH(16)) u0 (
        .clk_sys           (clk),
        .rst_sys           (rst_n[0]),
        .macrx_rxfifo_dval (dv[0]),
        .macrx_rxfifo_sop  (sp[0]),
        .macrx_rxfifo_eop  (ep[0]),
        .macrx_rxfifo_err  (er[0]),
        .macrx_rxfifo_data (bd[0]),
        .mm_slink_rdreq    (rq[0]),
        .slink_mm_empty    (emp[0]),
        .slink_mm_dval     (mdv[0]),
        .slink_mm_data     (q0),
        .slink_mm_pktcnt   (pc0),
        .slink_drop        (drp[0])
    );

    slink_rxpack #(.NBYTE(4), .DEPTH(16)) u1 (
        .clk_sys           (clk),
        .rst_sys           (rst_n[1]),
        .macrx_rxfifo_dval (dv[1]),
        .macrx_rxfifo_sop  (sp[1]),
        .macrx_rxfifo_eop  (ep[1]),
        .macrx_rxfifo_err  (er[1]),
        .macrx_rxfifo_data (bd[1]),
        .mm_slink_rdreq    (rq[1]),
        .slink_mm_empty    (emp[1]),
        .slink_mm_dval     (mdv[1]),
        .slink_mm_data     (q1),
        .slink_mm_pktcnt   (pc1),
        .slink_drop        (drp[1])
    );

    always @(negedge clk) begin
        if (drp[0]) drops0++;
        if (drp[1]) drops1++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word(input int u);
        return (u == 1) ? 64'(q1) : 64'(q0);
    endfunction

    function automatic logic [63:0] pcnt(input int u);
        return (u == 1) ? 64'(pc1) : 64'(pc0);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input int u, input logic [7:0] b,
                       input logic s, input logic e,
                       input logic r = 1'b0);
        dv[u] = 1'b1;
        bd[u] = b;
        sp[u] = s;
        ep[u] = e;
        er[u] = r;
        @(negedge clk);
        dv[u] = 1'b0;
        sp[u] = 1'b0;
        ep[u] = 1'b0;
        er[u] = 1'b0;
    endtask

    task automatic rd(input int u, input logic [63:0] exp,
                      input string tag);
        rq[u] = 1'b1;
        @(negedge clk);
        rq[u] = 1'b0;
        check({tag, " dval"}, mdv[u], 1);
        check(tag, word(u), exp);
    endtask

    initial begin
        rst_n = 2'b00;
        dv = '0; sp = '0; ep = '0; er = '0; rq = '0;
        bd[0] = 8'h00;
        bd[1] = 8'h00;
        tick(3);
        for (int u = 0; u < 2; u++) begin
            check("rst empty", emp[u], 1);
            check("rst dval", mdv[u], 0);
            check("rst data", word(u), 0);
            check("rst pktcnt", pcnt(u), 0);
            check("rst drop", drp[u], 0);
        end
        rst_n = 2'b11;
        tick(2);

        // 5-byte clean packet, NBYTE=2
        put(0, 8'h01, 1, 0);
        put(0, 8'h02, 0, 0);
        put(0, 8'h03, 0, 0);
        put(0, 8'h04, 0, 0);
        put(0, 8'h05, 0, 1);
        check("t1 empty t+1", emp[0], 1);
        tick();
        check("t1 empty t+2", emp[0], 0);
        check("t1 pktcnt", pcnt(0), 1);
        rd(0, 64'({1'b1, 1'b0, 1'b0, 16'h0102}), "t1 w0");
        rd(0, 64'({1'b0, 1'b0, 1'b0, 16'h0304}), "t1 w1");
        rd(0, 64'({1'b0, 1'b1, 1'b1, 16'h0500}), "t1 w2");
        tick();
        check("t1 pktcnt end", pcnt(0), 0);
        check("t1 empty end", emp[0], 1);

        // errored packet then clean packet
        d0 = drops0;
        for (int i = 0; i < 6; i++)
            put(0, 8'hA0 + 8'(i), i == 0, i == 5, i == 5);
        check("t3 drop t+1", drp[0], 0);
        tick();
        check("t3 drop t+2", drp[0], 1);
        tick();
        check("t3 drop t+3", drp[0], 0);
        tick();
        check("t3 drop count", drops0 - d0, 1);
        check("t3 empty", emp[0], 1);
        check("t3 pktcnt", pcnt(0), 0);
        put(0, 8'hAA, 1, 0);
        put(0, 8'hBB, 0, 0);
        put(0, 8'hCC, 0, 0);
        put(0, 8'hDD, 0, 1);
        tick();
        rd(0, 64'({1'b1, 1'b0, 1'b0, 16'hAABB}), "t3 w0");
        rd(0, 64'({1'b0, 1'b1, 1'b0, 16'hCCDD}), "t3 w1");
        tick();

        // 40-byte packet overflows a 16-word FIFO
        d0 = drops0;
        for (int i = 0; i < 40; i++)
            put(0, 8'(i), i == 0, i == 39);
        tick();
        check("t4 drop t+2", drp[0], 1);
        tick(2);
        check("t4 drop count", drops0 - d0, 1);
        check("t4 empty", emp[0], 1);
        check("t4 pktcnt", pcnt(0), 0);
        put(0, 8'h11, 1, 0);
        put(0, 8'h22, 0, 0);
        put(0, 8'h33, 0, 0);
        put(0, 8'h44, 0, 1);
        tick();
        check("t4 empty after", emp[0], 0);
        rd(0, 64'({1'b1, 1'b0, 1'b0, 16'h1122}), "t4 w0");
        rd(0, 64'({1'b0, 1'b1, 1'b0, 16'h3344}), "t4 w1");
        tick();

        // sop inside a packet rewinds it
        d0 = drops0;
        put(0, 8'hA1, 1, 0);
        put(0, 8'hA2, 0, 0);
        put(0, 8'hA3, 0, 0);
        put(0, 8'hB1, 1, 0);
        check("t5 drop t+1", drp[0], 1);
        put(0, 8'hB2, 0, 0);
        put(0, 8'hB3, 0, 0);
        put(0, 8'hB4, 0, 1);
        tick();
        rd(0, 64'({1'b1, 1'b0, 1'b0, 16'hB1B2}), "t5 w0");
        rd(0, 64'({1'b0, 1'b1, 1'b0, 16'hB3B4}), "t5 w1");
        tick();
        check("t5 empty", emp[0], 1);
        check("t5 pktcnt", pcnt(0), 0);
        check("t5 drop count", drops0 - d0, 1);

        // NBYTE=4: 8-byte packet and 1-byte packet
        for (int i = 0; i < 8; i++)
            put(1, 8'h10 + 8'(i), i == 0, i == 7);
        tick();
        rd(1, 64'({1'b1, 1'b0, 2'd0, 32'h10111213}), "t2 w0");
        rd(1, 64'({1'b0, 1'b1, 2'd0, 32'h14151617}), "t2 w1");
        put(1, 8'hAA, 1, 1);
        tick();
        rd(1, 64'({1'b1, 1'b1, 2'd1, 32'hAA000000}), "t2 one");
        tick();
        check("t2 pktcnt", pcnt(1), 0);
        check("t2 empty", emp[1], 1);

        // rdreq held high across commits
        rq[1] = 1'b1;
        tick(2);
        check("t6 idle dval", mdv[1], 0);
        check("t6 idle empty", emp[1], 1);
        put(1, 8'hC0, 1, 0);
        put(1, 8'hC1, 0, 0);
        put(1, 8'hC2, 0, 0);
        put(1, 8'hC3, 0, 1);
        check("t6 m0 pktcnt", pcnt(1), 0);
        tick();
        check("t6 m1 pktcnt", pcnt(1), 1);
        put(1, 8'hE0, 1, 1);
        check("t6 m2 dval", mdv[1], 1);
        check("t6 m2 data", word(1), 64'({1'b1, 1'b1, 2'd0, 32'hC0C1C2C3}));
        check("t6 m2 pktcnt", pcnt(1), 1);
        tick();
        check("t6 m3 pktcnt", pcnt(1), 1);
        check("t6 m3 dval", mdv[1], 0);
        tick();
        check("t6 m4 dval", mdv[1], 1);
        check("t6 m4 data", word(1), 64'({1'b1, 1'b1, 2'd1, 32'hE0000000}));
        check("t6 m4 pktcnt", pcnt(1), 1);
        tick();
        check("t6 m5 pktcnt", pcnt(1), 0);
        check("t6 m5 dval", mdv[1], 0);
        check("t6 m5 hold", word(1), 64'({1'b1, 1'b1, 2'd1, 32'hE0000000}));

        for (int i = 0; i < 8; i++)
            put(1, 8'h20 + 8'(i), i == 0, i == 7);
        tick(2);
        check("t6 b2b dval0", mdv[1], 1);
        check("t6 b2b w0", word(1), 64'({1'b1, 1'b0, 2'd0, 32'h20212223}));
        tick();
        check("t6 b2b dval1", mdv[1], 1);
        check("t6 b2b w1", word(1), 64'({1'b0, 1'b1, 2'd0, 32'h24252627}));
        tick();
        check("t6 b2b dval2", mdv[1], 0);
        check("t6 b2b pktcnt", pcnt(1), 0);

        // reset in the middle of a read burst
        for (int i = 0; i < 8; i++)
            put(1, 8'h30 + 8'(i), i == 0, i == 7);
        tick(2);
        check("t7 reading", mdv[1], 1);
        rst_n[1] = 1'b0;
        #1;
        check("t7 rst empty", emp[1], 1);
        check("t7 rst dval", mdv[1], 0);
        check("t7 rst pktcnt", pcnt(1), 0);
        check("t7 rst data", word(1), 0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        tick(2);
        check("t7 after empty", emp[1], 1);
        check("t7 after dval", mdv[1], 0);
        rq[1] = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
